divmod_iter: RTL and testbench
==============================

Name: divmod_iter

Overview:
- Parametrised iterative integer divider/modulo unit. It is the successor to the fixed divmod32/divmod64 instances attached to the CPU core.
- One module covers any operand width and retires 1, 2 or 4 quotient bits per cycle.
- It keeps the core's handshake: enable, unsgn_or_sgn, can_accept_cmd and data_ready.
- New over the fixed units: abort, a divide-by-zero flag, and defined signed overflow behaviour.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEPS, 1, quotient bits retired per calc cycle. Legal values are 1, 2 and 4. WIDTH % STEPS != 0 is an elaboration error.

Ports:
- clk  input  1  clock, all state updates on the posedge.
- rst  input  1  synchronous, active-high reset.
- in_enable  input  1  command request.
- in_unsgn_or_sgn  input  1  0 = unsigned, 1 = signed (two's complement).
- in_num  input  WIDTH  dividend.
- in_denom  input  WIDTH  divisor.
- in_abort  input  1  cancel the command in flight.
- out_quot  output  WIDTH  quotient, registered.
- out_rem  output  WIDTH  remainder, registered.
- out_can_accept_cmd  output  1  unit is idle and will accept in_enable.
- out_data_ready  output  1  out_quot/out_rem are valid for the last accepted command.
- out_div_by_zero  output  1  the last completed command had denom == 0.

Behaviour:

Reset:
- Synchronous; dominates every other input.
- State goes to StIdle. out_quot = 0, out_rem = 0, out_data_ready = 0, out_div_by_zero = 0, out_can_accept_cmd = 1.
- Reset mid-operation discards the command. No result is produced.

States: StIdle, StPrep, StCalc, StFixup. out_can_accept_cmd = 1 only in StIdle.

StIdle:
- If in_enable = 1, latch num, denom and mode, clear out_data_ready and out_div_by_zero, and go to StPrep.
- in_abort is ignored in StIdle; enable + abort in the same cycle is accepted.

StPrep (1 cycle):
- Record sign_n = num[MSB] & sgn and sign_d = denom[MSB] & sgn.
- Replace each signed operand by its magnitude (WIDTH-bit unsigned; |MIN| = 2^(WIDTH-1) fits).
- If denom == 0, go straight to StFixup with the div-zero flag set. Otherwise clear the partial remainder, load the counter with K = WIDTH/STEPS, and go to StCalc.

StCalc (exactly K cycles):
- Each cycle performs STEPS restoring-division steps, MSB first. The partial remainder is WIDTH+1 bits wide.
- The counter decrements each cycle. On the cycle the counter reaches 1, go to StFixup.

StFixup (1 cycle):
- Quotient is negated if sign_n ^ sign_d. Remainder is negated if sign_n (remainder takes the dividend's sign).
- Divide by zero: quot = all ones, rem = original num, out_div_by_zero = 1.
- Write out_quot/out_rem, set out_data_ready = 1, go to StIdle.

Latency:
- With the accepting edge as edge 0, out_data_ready rises after edge K+2.
- WIDTH=32/STEPS=1 gives 34 cycles. Divide by zero gives 2 cycles.

Result holding and back-to-back commands:
- out_data_ready and the results hold until the next command is accepted.
- A new command may be accepted in the cycle after data_ready rises.

Signed overflow:
- MIN / -1 gives quot = MIN and rem = 0. No flag is raised.

in_enable while busy:
- Ignored. It is not queued, and the latched operands are unchanged.

Abort:
- in_abort = 1 in StPrep, StCalc or StFixup sends the state to StIdle on the next edge.
- out_data_ready stays 0 and out_quot/out_rem keep their previous values.
- out_can_accept_cmd = 1 the cycle after the abort.

Input sampling:
- Inputs other than in_enable/in_abort are sampled only on the accepting edge. Changing them afterwards has no effect.

Test Plan:
1. WIDTH=32, STEPS=1, unsigned 100/7 -> quot 14, rem 2, data_ready exactly 34 cycles after accept, can_accept_cmd low for cycles 1..34. Check the same way that a second in_enable at cycle 10 is ignored.
2. Signed -100/7 -> quot 0xFFFFFFF2, rem 0xFFFFFFFE. Signed 100/-7 -> quot 0xFFFFFFF2, rem 0x00000002. Unsigned 0xFFFFFF9C/7 -> quot 0x24924916, rem 0x2.
3. num=0x1234, denom=0, either mode -> quot 0xFFFFFFFF, rem 0x1234, div_by_zero=1, data_ready 2 cycles after accept. A following 9/3 -> div_by_zero=0, quot 3, rem 0.
4. Signed 0x80000000 / 0xFFFFFFFF -> quot 0x80000000, rem 0, div_by_zero=0. Signed 0x80000000/2 -> quot 0xC0000000, rem 0.
5. Start 1000/3, assert in_abort at the 5th StCalc cycle -> can_accept_cmd=1 next cycle, data_ready stays 0, prior results unchanged. Then 9/3 -> 3, 0. Repeat with rst instead of abort -> all outputs at reset values.
6. WIDTH=64, STEPS=4: unsigned 0xFFFFFFFFFFFFFFFF/3 -> quot 0x5555555555555555, rem 0, latency 18 cycles. Follow it back-to-back with signed -7/2 -> quot -3, rem -1.

Source files
------------

// File: rtl/divmod_iter.sv
// Iterative signed/unsigned divider: STEPS quotient bits per cycle, result WIDTH/STEPS+2 cycles after accept (2 on divide-by-zero).
// Busy flow control: out_can_accept_cmd only in idle; in_enable while busy is dropped; in_abort cancels without a result.
module divmod_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_enable,
    input  logic             in_unsgn_or_sgn,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_denom,
    input  logic             in_abort,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_can_accept_cmd,
    output logic             out_data_ready,
    output logic             out_div_by_zero
);

    localparam int K  = WIDTH / STEPS;
    localparam int CW = $clog2(K + 1);

    generate
        if ((STEPS != 1 && STEPS != 2 && STEPS != 4) || (WIDTH % STEPS) != 0) begin : g_bad_params
            $error("divmod_iter: STEPS must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StCalc,
        StFixup
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_denom;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_prem;
    logic [CW-1:0]    r_cnt;
    logic             r_sgn;
    logic             r_sign_n;
    logic             r_sign_d;
    logic             r_dz;

    logic             w_sign_n;
    logic             w_sign_d;
    logic [WIDTH:0]   w_p;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StIdle: begin
                if (in_enable) begin
                    w_next = StPrep;
                end
            end
            StPrep: begin
                if (in_abort) begin
                    w_next = StIdle;
                end else if (r_denom == '0) begin
                    w_next = StFixup;
                end else begin
                    w_next = StCalc;
                end
            end
            StCalc: begin
                if (in_abort) begin
                    w_next = StIdle;
                end else if (r_cnt == CW'(1)) begin
                    w_next = StFixup;
                end
            end
            StFixup: begin
                w_next = StIdle;
            end
            default: begin
                w_next = StIdle;
            end
        endcase
    end

    assign out_can_accept_cmd = (r_state == StIdle);

    assign w_sign_n = r_num[WIDTH-1] & r_sgn;
    assign w_sign_d = r_denom[WIDTH-1] & r_sgn;

    // Restoring steps on a WIDTH+1 bit partial remainder; a set MSB of the difference means "does not fit".
    always_comb begin
        w_p    = {1'b0, r_prem};
        w_q    = r_quot;
        w_diff = '0;
        for (int i = 0; i < STEPS; i++) begin
            w_p    = {w_p[WIDTH-1:0], w_q[WIDTH-1]};
            w_q    = {w_q[WIDTH-2:0], 1'b0};
            w_diff = w_p - {1'b0, r_denom};
            if (!w_diff[WIDTH]) begin
                w_p    = w_diff;
                w_q[0] = 1'b1;
            end
        end
    end

    // r_num is left untouched on divide-by-zero so the original dividend can be returned as remainder.
    always_comb begin
        if (r_dz) begin
            w_quot_fix = '1;
            w_rem_fix  = r_num;
        end else begin
            w_quot_fix = (r_sign_n ^ r_sign_d) ? -r_quot : r_quot;
            w_rem_fix  = r_sign_n ? -r_prem : r_prem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num           <= '0;
            r_denom         <= '0;
            r_quot          <= '0;
            r_prem          <= '0;
            r_cnt           <= '0;
            r_sgn           <= 1'b0;
            r_sign_n        <= 1'b0;
            r_sign_d        <= 1'b0;
            r_dz            <= 1'b0;
            out_quot        <= '0;
            out_rem         <= '0;
            out_data_ready  <= 1'b0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_enable) begin
                        r_num           <= in_num;
                        r_denom         <= in_denom;
                        r_sgn           <= in_unsgn_or_sgn;
                        out_data_ready  <= 1'b0;
                        out_div_by_zero <= 1'b0;
                    end
                end
                StPrep: begin
                    r_sign_n <= w_sign_n;
                    r_sign_d <= w_sign_d;
                    r_dz     <= (r_denom == '0);
                    if (r_denom != '0) begin
                        r_quot  <= w_sign_n ? -r_num : r_num;
                        r_denom <= w_sign_d ? -r_denom : r_denom;
                        r_prem  <= '0;
                        r_cnt   <= CW'(K);
                    end
                end
                StCalc: begin
                    r_prem <= w_p[WIDTH-1:0];
                    r_quot <= w_q;
                    r_cnt  <= r_cnt - CW'(1);
                end
                StFixup: begin
                    if (!in_abort) begin
                        out_quot        <= w_quot_fix;
                        out_rem         <= w_rem_fix;
                        out_div_by_zero <= r_dz;
                        out_data_ready  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_iter.sv
// Directed bench for divmod_iter: a 32-bit/1-step unit and a 64-bit/4-step unit sharing clock and reset.
module tb_divmod_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, sgn, ab;
    logic [31:0] num, den;
    logic [31:0] q, r;
    logic        can, dr, dz;

    logic        en64, sgn64, ab64;
    logic [63:0] num64, den64;
    logic [63:0] q64, r64;
    logic        can64, dr64, dz64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divmod_iter #(.WIDTH(32), .STEPS(1)) dut32 (
        .clk(clk), .rst(rst), .in_enable(en), .in_unsgn_or_sgn(sgn),
        .in_num(num), .in_denom(den), .in_abort(ab),
        .out_quot(q), .out_rem(r), .out_can_accept_cmd(can),
        .out_data_ready(dr), .out_div_by_zero(dz)
    );

    divmod_iter #(.WIDTH(64), .STEPS(4)) dut64 (
        .clk(clk), .rst(rst), .in_enable(en64), .in_unsgn_or_sgn(sgn64),
        .in_num(num64), .in_denom(den64), .in_abort(ab64),
        .out_quot(q64), .out_rem(r64), .out_can_accept_cmd(can64),
        .out_data_ready(dr64), .out_div_by_zero(dz64)
    );

    // Issues one command, scrambles the operand inputs after the accepting edge and
    // counts edges until data_ready; busy_hi counts samples where the unit looked idle while busy.
    task automatic run32(input logic s, input logic [31:0] n, input logic [31:0] d,
                         output int cyc, output int busy_hi);
        @(negedge clk);
        en = 1'b1; sgn = s; num = n; den = d;
        @(negedge clk);
        en = 1'b0; sgn = ~s; num = 32'hDEAD_BEEF; den = 32'h5;
        cyc = 0;
        busy_hi = can ? 1 : 0;
        while (!dr && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!dr && can) busy_hi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL reset_quot got %h exp %h", q, 32'd0); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL reset_rem got %h exp %h", r, 32'd0); end
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", dr); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b exp 0", dz); end
        n_checks++; if (can !== 1'b1) begin n_fail++; $display("FAIL reset_can got %b exp 1", can); end
    endtask

    task automatic test_basic();
        int cyc, bh;
        run32(1'b0, 32'd100, 32'd7, cyc, bh);
        n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_quot got %h exp %h", q, 32'd14); end
        n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL basic_rem got %h exp %h", r, 32'd2); end
        n_checks++; if (cyc != 34) begin n_fail++; $display("FAIL basic_latency got %0d exp 34", cyc); end
        n_checks++; if (bh != 0) begin n_fail++; $display("FAIL basic_can_busy got %0d idle samples exp 0", bh); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz got %b exp 0", dz); end
        repeat (3) @(negedge clk);
        n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL basic_hold_ready got %b exp 1", dr); end
        n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_hold_quot got %h exp %h", q, 32'd14); end
    endtask

    task automatic test_busy_enable();
        int cyc;
        @(negedge clk);
        en = 1'b1; sgn = 1'b0; num = 32'd200; den = 32'd7;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (!dr && cyc < 200) begin
            @(negedge clk);
            cyc++;
            en = (cyc == 10);
            if (cyc == 10) begin num = 32'd50; den = 32'd5; end
        end
        en = 1'b0;
        n_checks++; if (q !== 32'd28) begin n_fail++; $display("FAIL busy_quot got %h exp %h", q, 32'd28); end
        n_checks++; if (r !== 32'd4) begin n_fail++; $display("FAIL busy_rem got %h exp %h", r, 32'd4); end
        n_checks++; if (cyc != 34) begin n_fail++; $display("FAIL busy_latency got %0d exp 34", cyc); end
        repeat (2) @(negedge clk);
        n_checks++; if (can !== 1'b1) begin n_fail++; $display("FAIL busy_not_queued_can got %b exp 1", can); end
        n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL busy_not_queued_ready got %b exp 1", dr); end
    endtask

    task automatic test_signed();
        int cyc, bh;
        run32(1'b1, 32'hFFFF_FF9C, 32'd7, cyc, bh);
        n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL sneg_num_quot got %h exp %h", q, 32'hFFFF_FFF2); end
        n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sneg_num_rem got %h exp %h", r, 32'hFFFF_FFFE); end
        run32(1'b1, 32'd100, 32'hFFFF_FFF9, cyc, bh);
        n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL sneg_den_quot got %h exp %h", q, 32'hFFFF_FFF2); end
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL sneg_den_rem got %h exp %h", r, 32'h2); end
        run32(1'b0, 32'hFFFF_FF9C, 32'd7, cyc, bh);
        n_checks++; if (q !== 32'h2492_4916) begin n_fail++; $display("FAIL unsg_big_quot got %h exp %h", q, 32'h2492_4916); end
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL unsg_big_rem got %h exp %h", r, 32'h2); end
    endtask

    task automatic test_div_zero();
        int cyc, bh;
        for (int m = 0; m < 2; m++) begin
            run32(m[0], 32'h1234, 32'd0, cyc, bh);
            n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_quot mode %0d got %h exp %h", m, q, 32'hFFFF_FFFF); end
            n_checks++; if (r !== 32'h1234) begin n_fail++; $display("FAIL dz_rem mode %0d got %h exp %h", m, r, 32'h1234); end
            n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag mode %0d got %b exp 1", m, dz); end
            n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL dz_latency mode %0d got %0d exp 2", m, cyc); end
        end
        run32(1'b0, 32'd9, 32'd3, cyc, bh);
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b exp 0", dz); end
        n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL dz_next_quot got %h exp %h", q, 32'd3); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL dz_next_rem got %h exp %h", r, 32'd0); end
    endtask

    task automatic test_overflow();
        int cyc, bh;
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bh);
        n_checks++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quot got %h exp %h", q, 32'h8000_0000); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL ovf_rem got %h exp %h", r, 32'd0); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL ovf_dz got %b exp 0", dz); end
        run32(1'b1, 32'h8000_0000, 32'd2, cyc, bh);
        n_checks++; if (q !== 32'hC000_0000) begin n_fail++; $display("FAIL min_half_quot got %h exp %h", q, 32'hC000_0000); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL min_half_rem got %h exp %h", r, 32'd0); end
    endtask

    task automatic test_abort();
        int cyc, bh;
        run32(1'b0, 32'd100, 32'd7, cyc, bh);
        @(negedge clk);
        en = 1'b1; sgn = 1'b0; num = 32'd1000; den = 32'd3;
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (can !== 1'b0) begin n_fail++; $display("FAIL abort_busy_before got %b exp 0", can); end
        ab = 1'b1;
        @(negedge clk);
        ab = 1'b0;
        n_checks++; if (can !== 1'b1) begin n_fail++; $display("FAIL abort_can got %b exp 1", can); end
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b exp 0", dr); end
        n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL abort_keep_quot got %h exp %h", q, 32'd14); end
        n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL abort_keep_rem got %h exp %h", r, 32'd2); end
        repeat (40) @(negedge clk);
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL abort_no_result got %b exp 0", dr); end
        run32(1'b0, 32'd9, 32'd3, cyc, bh);
        n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL abort_next_quot got %h exp %h", q, 32'd3); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL abort_next_rem got %h exp %h", r, 32'd0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        en = 1'b1; sgn = 1'b0; num = 32'd1000; den = 32'd3;
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL rstmid_quot got %h exp %h", q, 32'd0); end
        n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL rstmid_rem got %h exp %h", r, 32'd0); end
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b exp 0", dr); end
        n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL rstmid_dz got %b exp 0", dz); end
        n_checks++; if (can !== 1'b1) begin n_fail++; $display("FAIL rstmid_can got %b exp 1", can); end
        repeat (40) @(negedge clk);
        n_checks++; if (dr !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result got %b exp 0", dr); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        en64 = 1'b1; sgn64 = 1'b0; num64 = 64'hFFFF_FFFF_FFFF_FFFF; den64 = 64'd3;
        @(negedge clk);
        en64 = 1'b0; num64 = 64'd11; den64 = 64'd5;
        cyc = 0;
        while (!dr64 && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++; if (q64 !== 64'h5555_5555_5555_5555) begin n_fail++; $display("FAIL wide_quot got %h exp %h", q64, 64'h5555_5555_5555_5555); end
        n_checks++; if (r64 !== 64'd0) begin n_fail++; $display("FAIL wide_rem got %h exp %h", r64, 64'd0); end
        n_checks++; if (cyc != 18) begin n_fail++; $display("FAIL wide_latency got %0d exp 18", cyc); end
        en64 = 1'b1; sgn64 = 1'b1; num64 = 64'hFFFF_FFFF_FFFF_FFF9; den64 = 64'd2;
        @(negedge clk);
        en64 = 1'b0; sgn64 = 1'b0; num64 = 64'd11; den64 = 64'd5;
        n_checks++; if (can64 !== 1'b0 || dr64 !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got can=%b ready=%b exp can=0 ready=0", can64, dr64); end
        cyc = 0;
        while (!dr64 && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++; if (q64 !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL b2b_quot got %h exp %h", q64, 64'hFFFF_FFFF_FFFF_FFFD); end
        n_checks++; if (r64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL b2b_rem got %h exp %h", r64, 64'hFFFF_FFFF_FFFF_FFFF); end
        n_checks++; if (cyc != 18) begin n_fail++; $display("FAIL b2b_latency got %0d exp 18", cyc); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sgn = 1'b0; ab = 1'b0; num = '0; den = '0;
        en64 = 1'b0; sgn64 = 1'b0; ab64 = 1'b0; num64 = '0; den64 = '0;
        test_reset();
        test_basic();
        test_busy_enable();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
